// File: rtl/pc_sequencer_mt_pkg.sv
// Shared constants, hart-id width helper and hart id type for the multi-hart PC sequencer.
package pc_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int NUM_HARTS_DEF  = 4;
  localparam int INST_BYTES_DEF = 4;

  localparam logic [XLEN_DEF-1:0] RESET_VEC_DEF = 32'hFFFF_FFFC;
  localparam logic [XLEN_DEF-1:0] TRAP_VEC_DEF  = 32'h0000_0100;

  // A single hart still needs a 1-bit id field so ports never collapse to zero width.
  function automatic int hart_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [hart_w(NUM_HARTS_DEF)-1:0] hart_id_t;

endpackage

// File: rtl/pc_sequencer_mt_if.sv
// Fetch-control bundle between execute/control (master) and the PC sequencer (slave).
interface pc_sequencer_mt_if #(
  parameter int XLEN      = pc_pkg::XLEN_DEF,
  parameter int NUM_HARTS = pc_pkg::NUM_HARTS_DEF
);
  import pc_pkg::*;

  localparam int HW = hart_w(NUM_HARTS);

  logic                 i_en;
  logic [NUM_HARTS-1:0] i_hart_stall;
  logic                 i_redir_valid;
  logic [HW-1:0]        i_redir_hart;
  logic [XLEN-1:0]      i_redir_pc;
  logic                 o_fetch_valid;
  logic [HW-1:0]        o_fetch_hart;
  logic [XLEN-1:0]      o_fetch_pc;
  logic                 o_misalign;
  logic [HW-1:0]        o_misalign_hart;

  modport master (
    output i_en, i_hart_stall, i_redir_valid, i_redir_hart, i_redir_pc,
    input  o_fetch_valid, o_fetch_hart, o_fetch_pc, o_misalign, o_misalign_hart
  );

  modport slave (
    input  i_en, i_hart_stall, i_redir_valid, i_redir_hart, i_redir_pc,
    output o_fetch_valid, o_fetch_hart, o_fetch_pc, o_misalign, o_misalign_hart
  );

endinterface

// File: rtl/pc_sequencer_mt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr, cyclically.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = pc_pkg::hart_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_id,
  output logic         any_grant
);

  int unsigned w_idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    w_idx     = 0;
    // Offset 1..N visits every hart once, ending on ptr itself as lowest priority.
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!any_grant && req[w_idx]) begin
        any_grant    = 1'b1;
        grant[w_idx] = 1'b1;
        grant_id     = W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer_mt.sv
// Multi-hart fetch PC sequencer: one round-robin issue per cycle, registered outputs (latency 1).
// Optional PC_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VEC instead of being aligned down.
module pc_sequencer_mt
  import pc_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter int              NUM_HARTS  = NUM_HARTS_DEF,
  parameter int              INST_BYTES = INST_BYTES_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = {XLEN{1'b1}} - XLEN'(3),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(TRAP_VEC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_mt_if.slave      bus
);

  localparam int              HW       = hart_w(NUM_HARTS);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0]      r_pc [NUM_HARTS];
  logic [HW-1:0]        r_rr_ptr;
  logic                 r_fetch_valid;
  logic [HW-1:0]        r_fetch_hart;
  logic [XLEN-1:0]      r_fetch_pc;

  logic [NUM_HARTS-1:0] w_redir_hit;
  logic [NUM_HARTS-1:0] w_req;
  logic [NUM_HARTS-1:0] w_grant;
  logic [HW-1:0]        w_grant_id;
  logic                 w_any;
  logic                 w_issue;
  logic [XLEN-1:0]      w_grant_pc;
  logic [XLEN-1:0]      w_redir_tgt;

  // Out-of-range hart ids never match, so such redirects fall away here.
  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hit
    assign w_redir_hit[h] = bus.i_redir_valid && (bus.i_redir_hart == HW'(h));
  end

  // A hart being redirected is held back so its stale PC is never issued.
  assign w_req   = ~bus.i_hart_stall & ~w_redir_hit;
  assign w_issue = bus.i_en && w_any;

  rr_arbiter #(
    .N (NUM_HARTS),
    .W (HW)
  ) u_arb (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_id  (w_grant_id),
    .any_grant (w_any)
  );

  always_comb begin
    w_grant_pc = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_grant[h]) w_grant_pc |= r_pc[h];
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic          w_redir_misal;
  logic          r_misalign;
  logic [HW-1:0] r_misalign_hart;

  assign w_redir_misal = |(bus.i_redir_pc & LOW_MASK);
  assign w_redir_tgt   = w_redir_misal ? TRAP_VEC : bus.i_redir_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign      <= 1'b0;
      r_misalign_hart <= '0;
    end else begin
      r_misalign <= (|w_redir_hit) && w_redir_misal;
      if ((|w_redir_hit) && w_redir_misal) r_misalign_hart <= bus.i_redir_hart;
    end
  end

  assign bus.o_misalign      = r_misalign;
  assign bus.o_misalign_hart = r_misalign_hart;
`else
  assign w_redir_tgt         = bus.i_redir_pc & ~LOW_MASK;
  assign bus.o_misalign      = 1'b0;
  assign bus.o_misalign_hart = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int h = 0; h < NUM_HARTS; h++) r_pc[h] <= RESET_VEC;
      r_rr_ptr      <= HW'(NUM_HARTS - 1);
      r_fetch_valid <= 1'b0;
      r_fetch_hart  <= '0;
      r_fetch_pc    <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (w_redir_hit[h])              r_pc[h] <= w_redir_tgt;
        else if (w_issue && w_grant[h])  r_pc[h] <= r_pc[h] + XLEN'(INST_BYTES);
      end
      r_fetch_valid <= w_issue;
      if (w_issue) begin
        r_rr_ptr     <= w_grant_id;
        r_fetch_hart <= w_grant_id;
        r_fetch_pc   <= w_grant_pc;
      end
    end
  end

  assign bus.o_fetch_valid = r_fetch_valid;
  assign bus.o_fetch_hart  = r_fetch_hart;
  assign bus.o_fetch_pc    = r_fetch_pc;

endmodule
